// File: rtl/fp8_pkg.sv
// ---------------------------------------------------------------------------
// fp8_pkg
// Shared constants and types for the 8-bit minifloat arithmetic units.
// Format: sign [7], exponent [6:4] (bias 3), fraction [3:0] with hidden 1.
// Exponent 7 is reserved for infinity; value[6:0] == 0 encodes zero.
// ---------------------------------------------------------------------------
package fp8_pkg;

    localparam int EXP_W  = 3;
    localparam int FRAC_W = 4;
    localparam int MANT_W = FRAC_W + 1;   // fraction plus hidden one
    localparam int Q_W    = MANT_W + 1;   // quotient / partial remainder width

    localparam int              BIAS    = 3;
    localparam int              EXP_MAX = 6;
    localparam logic [EXP_W-1:0] EXP_INF = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        NORM,
        DONE
    } state_t;

endpackage

// File: rtl/mant_div_step.sv
// ---------------------------------------------------------------------------
// mant_div_step
// One combinational restoring-division step on the mantissas.
//   rem       in  6  current partial remainder (always < 2 * divisor)
//   divisor   in  5  divisor mantissa {1, frac}
//   rem_next  out 6  remainder for the next step, already shifted left
//   q_bit     out 1  quotient bit produced by this step
// ---------------------------------------------------------------------------
module mant_div_step
    import fp8_pkg::*;
(
    input  logic [Q_W-1:0]    rem,
    input  logic [MANT_W-1:0] divisor,
    output logic [Q_W-1:0]    rem_next,
    output logic              q_bit
);

    logic [Q_W-1:0] div_ext;
    logic [Q_W-1:0] kept;

    assign div_ext = {1'b0, divisor};
    assign q_bit   = (rem >= div_ext);
    // The kept remainder is below the divisor (< 32), so the left shift
    // never loses a significant bit.
    assign kept     = q_bit ? (rem - div_ext) : rem;
    assign rem_next = kept << 1;

endmodule

// File: rtl/fp8_div_seq.sv
// ---------------------------------------------------------------------------
// fp8_div_seq
// Sequential minifloat divider: result = a / b, truncated, 8-cycle latency.
// One quotient bit is produced per cycle by a single restoring step that
// the FSM iterates six times, then the quotient is normalised and the
// special cases (divide-by-zero, infinity, zero, over/underflow) applied.
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-high reset
//   start        in   request pulse, sampled only in IDLE
//   a, b         in   dividend / divisor, latched on the accepting edge
//   busy         out  high from the accepting edge until done deasserts
//   done         out  one-cycle pulse, result/flags valid from this cycle
//   result       out  quotient, held until the next operation completes
//   overflow     out  exponent > 6, infinite or divide-by-zero outcome
//   underflow    out  magnitude < 2^-3, flushed to zero
//   zero         out  result encodes zero
//   div_by_zero  out  divisor encodes zero
// ---------------------------------------------------------------------------
module fp8_div_seq
    import fp8_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic       busy,
    output logic       done,
    output logic [7:0] result,
    output logic       overflow,
    output logic       underflow,
    output logic       zero,
    output logic       div_by_zero
);

    state_t              state;
    logic [2:0]          count;

    // Operand fields kept after the accepting edge.
    logic                sign_r;
    logic [EXP_W-1:0]    a_exp_r;
    logic [EXP_W-1:0]    b_exp_r;
    logic [MANT_W-1:0]   b_mant_r;
    logic                a_zero_r;
    logic                b_zero_r;

    logic [Q_W-1:0]      rem_r;
    logic [Q_W-1:0]      quo_r;
    logic [Q_W-1:0]      rem_next;
    logic                q_bit;

    logic signed [4:0]   e_raw;
    logic signed [4:0]   e_norm;
    logic [FRAC_W-1:0]   frac;
    logic [7:0]          norm_result;
    logic                norm_ov;
    logic                norm_uf;
    logic                norm_dz;

    mant_div_step u_step (
        .rem      (rem_r),
        .divisor  (b_mant_r),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    // Normalisation and special-case selection, consumed in NORM.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        e_raw       = $signed({2'b00, a_exp_r}) - $signed({2'b00, b_exp_r})
                      + $signed(5'(BIAS));
        frac        = quo_r[3:0];
        e_norm      = e_raw - 5'sd1;
        norm_ov     = 1'b0;
        norm_uf     = 1'b0;
        norm_dz     = 1'b0;

        // Quotient is in [16, 62]; a set MSB means the ratio is >= 1.
        if (quo_r[Q_W-1]) begin
            frac   = quo_r[4:1];
            e_norm = e_raw;
        end

        norm_result = {sign_r, e_norm[EXP_W-1:0], frac};

        if (b_zero_r) begin
            norm_result = {sign_r, EXP_INF, {FRAC_W{1'b0}}};
            norm_ov     = 1'b1;
            norm_dz     = 1'b1;
        end else if (a_exp_r == EXP_INF) begin
            norm_result = {sign_r, EXP_INF, {FRAC_W{1'b0}}};
            norm_ov     = 1'b1;
        end else if (a_zero_r || (b_exp_r == EXP_INF)) begin
            norm_result = {sign_r, 7'b0};
        end else if (e_norm > $signed(5'(EXP_MAX))) begin
            norm_result = {sign_r, EXP_INF, {FRAC_W{1'b0}}};
            norm_ov     = 1'b1;
        end else if (e_norm < 5'sd0) begin
            norm_result = {sign_r, 7'b0};
            norm_uf     = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            count       <= 3'd0;
            sign_r      <= 1'b0;
            a_exp_r     <= '0;
            b_exp_r     <= '0;
            b_mant_r    <= '0;
            a_zero_r    <= 1'b0;
            b_zero_r    <= 1'b0;
            rem_r       <= '0;
            quo_r       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= 8'h00;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
            zero        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sign_r   <= a[7] ^ b[7];
                        a_exp_r  <= a[6:4];
                        b_exp_r  <= b[6:4];
                        b_mant_r <= {1'b1, b[3:0]};
                        a_zero_r <= (a[6:0] == 7'd0);
                        b_zero_r <= (b[6:0] == 7'd0);
                        rem_r    <= {1'b0, 1'b1, a[3:0]};
                        quo_r    <= '0;
                        count    <= 3'd5;
                        busy     <= 1'b1;
                        state    <= DIVIDE;
                    end
                end
                DIVIDE: begin
                    rem_r <= rem_next;
                    quo_r <= {quo_r[Q_W-2:0], q_bit};
                    if (count == 3'd0) begin
                        state <= NORM;
                    end else begin
                        count <= count - 3'd1;
                    end
                end
                NORM: begin
                    result      <= norm_result;
                    overflow    <= norm_ov;
                    underflow   <= norm_uf;
                    zero        <= (norm_result[6:0] == 7'd0);
                    div_by_zero <= norm_dz;
                    done        <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/fp8_div_seq.md
# fp8_div_seq

Sequential divider for the team's 8-bit minifloat format: sign bit [7], exponent [6:4] with bias 3 (3 is 2^0), fraction [3:0] with a hidden leading 1. It computes a/b with a restoring shift-subtract loop over multiple cycles and uses a start/done handshake. It is the inverse-operation companion to the combinational add/sub unit and reports the same Overflow/Underflow/Zero flag set, plus divide-by-zero.

## Interface
Parameters:
- none; widths and constants are fixed in the shared package.

Ports:
- clk  in  1  rising-edge clock; the block uses one clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request pulse; sampled only in IDLE.
- a  in  8  dividend; sampled on the accepting edge.
- b  in  8  divisor; sampled on the accepting edge.
- busy  out  1  high from the accepting edge until done deasserts.
- done  out  1  one-cycle pulse; result and flags are valid from this cycle on.
- result  out  8  quotient in minifloat format; registered.
- overflow  out  1  result exponent > 6, or an infinite or divide-by-zero outcome.
- underflow  out  1  result magnitude < 2^-3, flushed to zero.
- zero  out  1  result encodes zero.
- div_by_zero  out  1  b encodes zero.

## Operation
- Zero encoding: value[6:0] == 0, with either sign. Exponent 7 is reserved as infinity, with fraction ignored on input.
- Mantissa: Ma = {1, a[3:0]} and Mb = {1, b[3:0]}, 5 bits each.
- Quotient: q = floor((Ma << 5) / Mb), 6 bits, produced one bit per cycle by restoring division.
- Remainder: discarded, so the result is truncated (no rounding).
- Exponent: e = a[6:4] − b[6:4] + 3, computed in 5-bit signed arithmetic.
  - If q[5] = 1: frac = q[4:1].
  - Else: frac = q[3:0] and e = e − 1.
- Sign: result[7] = a[7] ^ b[7] in every case, including special cases.
- Special cases, applied in this priority order:
  1. b zero: result {s, 3'b111, 4'b0}; set div_by_zero and overflow.
  2. a exponent 7: result {s, 3'b111, 4'b0}; set overflow.
  3. a zero, or b exponent 7: result {s, 7'b0}; set zero.
  4. e > 6: result {s, 3'b111, 4'b0}; set overflow.
  5. e < 0: result {s, 7'b0}; set underflow and zero.
- Special cases still run the full latency, so latency is always the same.
- FSM states:
  - IDLE: on start, latch a and b, go to DIVIDE.
  - DIVIDE: counter 5→0, one quotient bit per cycle; go to NORM after count 0.
  - NORM: normalise, apply special cases, load output registers.
  - DONE: done = 1; go to IDLE.
- start while busy is ignored; no queuing.

## Timing
- Reset values: result 0x00; busy, done, overflow, underflow, zero, div_by_zero all 0; FSM in IDLE; counter 0.
- Cycle 0: the edge at which start is sampled high in IDLE; busy = 1 after this edge.
- Cycles 1–6: DIVIDE.
- Cycle 7: NORM.
- Cycle 8: done = 1 and result/flags updated.
- After cycle 8: busy and done return to 0 on the next edge.
- Latency from start to done is 8 cycles.
- result and flags hold their values until the next NORM. They are not cleared at the next start.
- A new start is accepted in the first cycle after done; the throughput is one operation per 9 cycles.
- rst asserted mid-operation: all state returns to reset values immediately; no done is generated for the aborted operation.
- start held high continuously: a new operation begins every 9 cycles.

## Structure
- Package fp8_pkg holds:
  - field widths (EXP_W = 3, FRAC_W = 4);
  - BIAS = 3, EXP_MAX = 6, EXP_INF = 3'b111;
  - the FSM state enum {IDLE, DIVIDE, NORM, DONE}.
- Sub-module mant_div_step: one combinational restoring step.
  - Inputs: partial remainder (6 bits) and divisor (5 bits).
  - Outputs: the next remainder and one quotient bit.
  - It is instantiated once and iterated by the FSM.

## Test plan
- a=0x48 (3.0), b=0x40 (2.0) → done at cycle 8; result 0x38 (1.5); all flags 0.
- a=0x30 (1.0), b=0x48 (3.0) → q=21 and normalisation shift; result 0x15; flags 0.
- a=0xE0, b=0x10 → e=8; result 0xF0; overflow=1.
- a=0x10, b=0x60 → e=−2; result 0x00; underflow=1, zero=1.
- a=0x30, b=0x80 → result 0xF0; div_by_zero=1, overflow=1, still at 8-cycle latency.
- Control sequencing, in one run:
  - Pulse start again during DIVIDE → ignored.
  - Assert rst at cycle 4 → busy=0, no done, outputs 0x00.
  - Restart with 0x48/0x40 → result 0x38 after 8 cycles.
